// File: rtl/serial_parity_rx_pkg.sv
// Shared definitions for the parity-protected serial link receiver.
//   rx_state_e : receiver FSM state encoding (3 bits)
//   cnt_w()    : counter width for a modulus, never below 1 bit
package serial_parity_rx_pkg;

  localparam int unsigned STATE_W     = 3;
  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Width of a counter running 0..n-1; timer uses CLKS_PER_BIT, index uses DATA_W.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_parity_rx_bit_timer.sv
// Per-bit timer: free-running 0..CLKS_PER_BIT-1 counter with synchronous clear.
//   clk, rst : clock, async active-high reset
//   clr      : force counter to 0 on the next edge
//   mid_c    : counter at CLKS_PER_BIT/2-1 (middle of a bit)
//   end_c    : counter at CLKS_PER_BIT-1 (last cycle of a bit, wraps next)
module bit_timer
  import serial_parity_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic mid_c,
  output logic end_c
);

  localparam int unsigned TMR_W = cnt_w(CLKS_PER_BIT);

  logic [TMR_W-1:0] cnt;

  assign mid_c = (cnt == TMR_W'(CLKS_PER_BIT / 2 - 1));
  assign end_c = (cnt == TMR_W'(CLKS_PER_BIT - 1));

  // Counter register; wraps at the end of each bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || end_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TMR_W'(1);
    end
  end

endmodule

// File: rtl/xor_gate.sv
// Two-input XOR used for running parity accumulation.
//   a, b : operands
//   y    : a ^ b
module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/serial_parity_rx.sv
// Serial receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
//   clk, rst   : clock, async active-high reset
//   rx         : serial line (idles high, asynchronous to clk)
//   data       : last received word, updated with valid
//   valid      : one-cycle pulse at frame completion
//   parity_err : parity mismatch on last frame (held until next valid)
//   frame_err  : stop bit sampled low on last frame (held until next valid)
//   busy       : receiver not in IDLE
module serial_parity_rx
  import serial_parity_rx_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned IDX_W = cnt_w(DATA_W);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  rx_state_e          state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               acc, acc_nxt;
  logic               perr, perr_nxt;
  logic [DATA_W-1:0]  shreg, shreg_nxt;
  logic [DATA_W-1:0]  data_nxt;
  logic               valid_nxt, parity_err_nxt, frame_err_nxt;

  logic tmr_clr_c, tmr_mid_c, tmr_end_c;
  logic acc_x_c;

  // Two-flop synchroniser, preset to line-idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr_c),
    .mid_c (tmr_mid_c),
    .end_c (tmr_end_c)
  );

  // Running parity: accumulator XOR current line sample.
  xor_gate u_par_xor (
    .a (acc),
    .b (rx_s),
    .y (acc_x_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    acc_nxt        = acc;
    perr_nxt       = perr;
    shreg_nxt      = shreg;
    data_nxt       = data;
    valid_nxt      = 1'b0;
    parity_err_nxt = parity_err;
    frame_err_nxt  = frame_err;
    tmr_clr_c      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // Timer held at 0 so START begins counting from a clean edge.
        tmr_clr_c = 1'b1;
        if (!rx_s) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (tmr_mid_c) begin
          if (!rx_s) begin
            state_nxt = ST_DATA;
            tmr_clr_c = 1'b1;
            idx_nxt   = '0;
            acc_nxt   = 1'(PARITY_ODD);
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tmr_end_c) begin
          shreg_nxt[idx] = rx_s;
          acc_nxt        = acc_x_c;
          if (idx == IDX_W'(DATA_W - 1)) begin
            state_nxt = ST_PARITY;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tmr_end_c) begin
          perr_nxt  = acc_x_c;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tmr_end_c) begin
          valid_nxt      = 1'b1;
          data_nxt       = shreg;
          parity_err_nxt = perr;
          frame_err_nxt  = ~rx_s;
          state_nxt      = rx_s ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        // Held-low line must return high before a new start is accepted.
        if (rx_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      acc        <= 1'b0;
      perr       <= 1'b0;
      shreg      <= '0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      acc        <= acc_nxt;
      perr       <= perr_nxt;
      shreg      <= shreg_nxt;
      data       <= data_nxt;
      valid      <= valid_nxt;
      parity_err <= parity_err_nxt;
      frame_err  <= frame_err_nxt;
      busy       <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
- Serial receiver for the team's parity-protected serial link. It is the receiving end of the XOR-based parity generator/transmitter.
- It deserialises frames of start bit, DATA_W data bits (LSB first), one parity bit and one stop bit.
- It recomputes parity with a running XOR and flags parity and framing errors.
- It sits between the external rx pin and downstream byte consumers.

Parameters:
- DATA_W, 8, number of data bits per frame.
- CLKS_PER_BIT, 4, clock cycles per serial bit. Must be an even number, 4 or greater.
- PARITY_ODD, 0, selects parity sense: 0 = even parity, 1 = odd parity.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idles high. Asynchronous to clk.
- data  output  DATA_W  last received data word; updated together with valid.
- valid  output  1  one-cycle pulse: a frame has completed, and data/parity_err/frame_err are current.
- parity_err  output  1  parity mismatch on the last frame; held until the next valid.
- frame_err  output  1  stop bit sampled as 0 on the last frame; held until the next valid.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: data=0, valid=0, parity_err=0, frame_err=0, busy=0.
  - State goes to IDLE; bit timer, bit index and parity accumulator are cleared.
  - Both synchroniser flops are preset to 1 (line idle).
  - Reset asserted mid-frame abandons the frame; no valid is produced.
- Synchroniser: rx passes through 2 flops to give rx_s. All decisions below use rx_s.
- State IDLE:
  - rx_s=0 → enter START and clear the timer.
- State START:
  - At timer = CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
  - rx_s=0 → enter DATA, timer=0, bit index=0, parity accumulator = PARITY_ODD.
  - rx_s=1 → treat as a glitch and return to IDLE. No valid, error flags unchanged.
- State DATA:
  - At timer = CLKS_PER_BIT-1, sample rx_s into shift register bit [index], LSB first.
  - On the same sample, update acc ^= rx_s.
  - Timer wraps to 0 at each sample.
  - After the sample at index DATA_W-1 → enter PARITY.
- State PARITY:
  - At timer = CLKS_PER_BIT-1, sample rx_s.
  - perr = acc ^ rx_s. perr=1 means error: even mode requires an even count of ones over data plus parity bit; odd mode requires an odd count.
  - Enter STOP.
- State STOP:
  - At timer = CLKS_PER_BIT-1, sample rx_s.
  - Next cycle: valid=1, data=shift register, parity_err=perr, frame_err=~stop_sample.
  - If stop_sample=1 → enter IDLE. Otherwise → enter BREAK.
- State BREAK:
  - Wait for rx_s=1, then enter IDLE. This prevents a held-low line from being taken as a new start bit.
- Latency: valid rises 1 clk after the stop-bit sample. From the first rx low to valid it takes 2 + CLKS_PER_BIT/2 + (DATA_W+2)*CLKS_PER_BIT + 1 clks; with defaults that is 45.
- Back-to-back frames: a start bit arriving right after the stop bit is detected from IDLE. There are no dead cycles beyond the IDLE check.
- data and the flags are registered and stable between valid pulses.
- valid is never asserted for two consecutive cycles.

Decomposition:
- Shared package:
  - State encoding: IDLE, START, DATA, PARITY, STOP, BREAK as a 3-bit localparam set.
  - Timer width constant: $clog2(CLKS_PER_BIT).
  - Index width constant: $clog2(DATA_W).
- Sub-module bit_timer:
  - Free-running counter with clear input and wrap at CLKS_PER_BIT-1.
  - Outputs a mid-bit strobe and an end-of-bit strobe.
  - Shared with the transmitter.
- Parity accumulation is reused through the existing xor_gate.

Test Plan (defaults: DATA_W=8, CLKS_PER_BIT=4, even parity):
- Send 0xA5, parity bit 0, stop 1 → one valid pulse; data=0xA5, parity_err=0, frame_err=0; valid 45 clks after start edge.
- Send 0xA5, parity bit 1, stop 1 → valid; data=0xA5, parity_err=1, frame_err=0.
- Send 0x3C with stop bit 0, then hold rx low 20 clks → valid with frame_err=1; busy stays 1 (BREAK) until rx goes high; no second valid.
- rx low for 1 clk, then high → no valid; busy returns to 0 within 5 clks.
- Assert rst during data bit 4 of a frame → all outputs 0 immediately (asynchronous); the remainder of the frame produces no valid; the next clean frame 0x5A is received correctly.
- Back-to-back 0x00 (parity 0) then 0xFF (parity 0) with no idle gap → two valid pulses 44 clks apart; data=0x00 then 0xFF; both error-free.
